// File: rtl/mem_arbiter.sv
// Memory arbiter between a CPU and an IOP sharing one word-addressed memory.
// CPU accesses take two clocks (address, data) followed by a one-clock ack;
// the IOP is granted a fixed window of IOP_WINDOW clocks during which it
// drives the memory bus directly. With both requesting, grants alternate.
// Optional grant statistics are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int unsigned IOP_WINDOW = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic [15:31] cpu_addr,
    input  logic [0:31]  cpu_wdata,
    input  logic [0:3]   cpu_wr_en,
    output logic [0:31]  cpu_rdata,
    output logic         cpu_ack,
    input  logic         iop_req,
    output logic         iop_active,
    input  logic [15:31] iop_addr,
    input  logic [0:31]  iop_wdata,
    input  logic [0:3]   iop_wr_en,
    output logic [15:31] mem_addr,
    output logic [0:31]  mem_wdata,
    output logic [0:3]   mem_wr_en,
    input  logic [0:31]  mem_rdata,
    output logic [0:15]  cpu_grant_count,
    output logic [0:15]  iop_grant_count
);

    typedef enum logic [1:0] {
        StIdle,
        StCpuAddr,
        StCpuData,
        StIopWin
    } state_e;

    // Counter runs IOP_WINDOW-1 down to 0, giving exactly IOP_WINDOW clocks.
    localparam logic [3:0] WinLoad = 4'(IOP_WINDOW - 1);

    state_e      state_q, state_d;
    logic [3:0]  win_cnt_q, win_cnt_d;
    logic        last_was_iop_q, last_was_iop_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [0:31] cpu_rdata_q, cpu_rdata_d;

    // Next-state logic: arbitration, window countdown and read-data capture.
    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        last_was_iop_d = last_was_iop_q;
        cpu_ack_d      = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        case (state_q)
            StIdle: begin
                // IOP wins unless it just had the bus and the CPU is waiting.
                if (iop_req && !(last_was_iop_q && cpu_req)) begin
                    state_d   = StIopWin;
                    win_cnt_d = WinLoad;
                end else if (cpu_req) begin
                    state_d = StCpuAddr;
                end
            end
            StCpuAddr: begin
                state_d        = StCpuData;
                last_was_iop_d = 1'b0;
            end
            StCpuData: begin
                state_d     = StIdle;
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = mem_rdata;
            end
            StIopWin: begin
                if (win_cnt_q == 4'd0) begin
                    state_d        = StIdle;
                    last_was_iop_d = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            win_cnt_q      <= 4'd0;
            last_was_iop_q <= 1'b0;
            cpu_ack_q      <= 1'b0;
            cpu_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            win_cnt_q      <= win_cnt_d;
            last_was_iop_q <= last_was_iop_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_rdata_q    <= cpu_rdata_d;
        end
    end

    // Memory bus mux; IOP inputs are only looked at while it owns the bus,
    // so a floating IOP bus never reaches memory.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = '0;
        case (state_q)
            StCpuAddr: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wr_en = cpu_wr_en;
            end
            StCpuData: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            StIopWin: begin
                mem_addr  = iop_addr;
                mem_wdata = iop_wdata;
                mem_wr_en = iop_wr_en;
            end
            default: ;
        endcase
    end

    // Grant decoded from state so reset removes it immediately.
    assign iop_active = (state_q == StIopWin);
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] cpu_cnt_q, cpu_cnt_d;
    logic [15:0] iop_cnt_q, iop_cnt_d;

    // Count grants on the IDLE exit edges; both wrap naturally.
    always_comb begin
        cpu_cnt_d = cpu_cnt_q;
        iop_cnt_d = iop_cnt_q;
        if (state_q == StIdle && state_d == StCpuAddr) begin
            cpu_cnt_d = cpu_cnt_q + 16'd1;
        end
        if (state_q == StIdle && state_d == StIopWin) begin
            iop_cnt_d = iop_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_cnt_q <= 16'd0;
            iop_cnt_q <= 16'd0;
        end else begin
            cpu_cnt_q <= cpu_cnt_d;
            iop_cnt_q <= iop_cnt_d;
        end
    end

    assign cpu_grant_count = cpu_cnt_q;
    assign iop_grant_count = iop_cnt_q;
`else
    assign cpu_grant_count = '0;
    assign iop_grant_count = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small memory model.
// Expected grant counts follow MEM_ARBITER_STATS_EN.
module tb_mem_arbiter;

    localparam int unsigned Win = 4;

    logic         clock;
    logic         reset;
    logic         cpu_req;
    logic [15:31] cpu_addr;
    logic [0:31]  cpu_wdata;
    logic [0:3]   cpu_wr_en;
    logic [0:31]  cpu_rdata;
    logic         cpu_ack;
    logic         iop_req;
    logic         iop_active;
    logic [15:31] iop_addr;
    logic [0:31]  iop_wdata;
    logic [0:3]   iop_wr_en;
    logic [15:31] iop_addr_drv;
    logic [0:31]  iop_wdata_drv;
    logic [0:3]   iop_wr_en_drv;
    logic [15:31] mem_addr;
    logic [0:31]  mem_wdata;
    logic [0:3]   mem_wr_en;
    logic [0:31]  mem_rdata;
    logic [0:15]  cpu_grant_count;
    logic [0:15]  iop_grant_count;

    // IOP floats its bus unless granted.
    assign iop_addr  = iop_active ? iop_addr_drv  : 'z;
    assign iop_wdata = iop_active ? iop_wdata_drv : 'z;
    assign iop_wr_en = iop_active ? iop_wr_en_drv : 'z;

    mem_arbiter #(
        .IOP_WINDOW(Win)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_wr_en      (cpu_wr_en),
        .cpu_rdata      (cpu_rdata),
        .cpu_ack        (cpu_ack),
        .iop_req        (iop_req),
        .iop_active     (iop_active),
        .iop_addr       (iop_addr),
        .iop_wdata      (iop_wdata),
        .iop_wr_en      (iop_wr_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wr_en      (mem_wr_en),
        .mem_rdata      (mem_rdata),
        .cpu_grant_count(cpu_grant_count),
        .iop_grant_count(iop_grant_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: byte-enabled write, read data one clock after address.
    logic [0:31] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [0:31] pl_data;
    logic [5:0]  idx;
    assign idx = mem_addr[26:31];

    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wr_en[b]) mem[idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        mem_rdata <= mem[idx];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic cpu_access(input logic [16:0] a, input logic [31:0] wd, input logic [3:0] we,
                              input bit drop_early, input logic [31:0] exp_rd, input string tag);
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wr_en = we;
        tick();
        check({tag, "_addr_phase_wen"}, 32'(mem_wr_en), 32'(we));
        check({tag, "_addr_phase_maddr"}, 32'(mem_addr), 32'(a));
        check({tag, "_addr_phase_ack"}, 32'(cpu_ack), 32'd0);
        tick();
        if (drop_early) cpu_req = 1'b0;
        check({tag, "_data_phase_wen"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_data_phase_ack"}, 32'(cpu_ack), 32'd0);
        tick();
        check({tag, "_ack"}, 32'(cpu_ack), 32'd1);
        check({tag, "_rdata"}, cpu_rdata, exp_rd);
        cpu_req = 1'b0;
        tick();
        check({tag, "_ack_end"}, 32'(cpu_ack), 32'd0);
        check({tag, "_rdata_held"}, cpu_rdata, exp_rd);
    endtask

    task automatic iop_window(input logic [16:0] a, input logic [31:0] wd, input logic [3:0] we,
                              input string tag);
        iop_req       = 1'b1;
        iop_addr_drv  = a;
        iop_wdata_drv = wd;
        iop_wr_en_drv = we;
        tick();
        // Full window must run even though the request drops right away.
        iop_req = 1'b0;
        for (int i = 1; i <= int'(Win); i++) begin
            check($sformatf("%s_active_c%0d", tag, i), 32'(iop_active), 32'd1);
            check($sformatf("%s_wen_c%0d", tag, i), 32'(mem_wr_en), 32'(we));
            tick();
        end
        check({tag, "_active_after"}, 32'(iop_active), 32'd0);
        check({tag, "_maddr_idle"}, 32'(mem_addr), 32'd0);
        check({tag, "_wen_idle"}, 32'(mem_wr_en), 32'd0);
    endtask

    logic [1:14] iop_seq;
    logic [1:14] ack_seq;
    logic [31:0] exp_cpu_cnt;
    logic [31:0] exp_iop_cnt;

    initial begin
        reset         = 1'b1;
        cpu_req       = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        cpu_wr_en     = '0;
        iop_req       = 1'b0;
        iop_addr_drv  = '0;
        iop_wdata_drv = '0;
        iop_wr_en_drv = '0;
        pl_en         = 1'b0;
        pl_addr       = '0;
        pl_data       = '0;
        #1;
        check("rst_iop_active", 32'(iop_active), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_wen", 32'(mem_wr_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_cpu_cnt", 32'(cpu_grant_count), 32'd0);
        check("rst_iop_cnt", 32'(iop_grant_count), 32'd0);
        tick();
        reset = 1'b0;

        // CPU read of a preloaded word.
        preload(6'h21, 32'h0E000000);
        cpu_access(17'h21, 32'h0, 4'h0, 1'b0, 32'h0E000000, "cpu_rd");

        // IOP window writing one word.
        preload(6'h2A, 32'h0);
        iop_window(17'h2A, 32'h32100021, 4'hF, "iop_wr");
        check("iop_wr_mem", mem[6'h2A], 32'h32100021);

        // CPU partial write with request dropped in the data phase.
        preload(6'h10, 32'hAAAAAAAA);
        cpu_access(17'h10, 32'h12345678, 4'h3, 1'b1, 32'hAAAAAAAA, "cpu_wr");
        check("cpu_wr_mem", mem[6'h10], 32'hAAAA5678);

        // Contention from reset: IOP, CPU, IOP, CPU...
        reset         = 1'b1;
        cpu_req       = 1'b1;
        iop_req       = 1'b1;
        cpu_addr      = 17'h05;
        cpu_wr_en     = 4'h0;
        iop_addr_drv  = 17'h07;
        iop_wr_en_drv = 4'h0;
        tick();
        reset   = 1'b0;
        iop_seq = 14'b1111_0000_1111_00;
        ack_seq = 14'b0000_0001_0000_00;
        for (int c = 1; c <= 14; c++) begin
            tick();
            check($sformatf("contend_iop_c%0d", c), 32'(iop_active), 32'(iop_seq[c]));
            check($sformatf("contend_ack_c%0d", c), 32'(cpu_ack), 32'(ack_seq[c]));
            if (c == 2) check("contend_iop_addr", 32'(mem_addr), 32'h07);
            if (c == 6) check("contend_cpu_addr", 32'(mem_addr), 32'h05);
        end
        cpu_req = 1'b0;
        iop_req = 1'b0;
        tick();
        tick();
        tick();

        // Reset in window clock 2: grant and write enable drop at once.
        preload(6'h30, 32'h0);
        iop_req       = 1'b1;
        iop_addr_drv  = 17'h30;
        iop_wdata_drv = 32'h5A5A5A5A;
        iop_wr_en_drv = 4'hF;
        tick();
        iop_req = 1'b0;
        check("rstwin_active_c1", 32'(iop_active), 32'd1);
        tick();
        check("rstwin_active_c2", 32'(iop_active), 32'd1);
        iop_wdata_drv = 32'hDEADBEEF;
        reset         = 1'b1;
        #1;
        check("rstwin_active", 32'(iop_active), 32'd0);
        check("rstwin_wen", 32'(mem_wr_en), 32'd0);
        check("rstwin_maddr", 32'(mem_addr), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rstwin_idle_active", 32'(iop_active), 32'd0);
        check("rstwin_mem", mem[6'h30], 32'h5A5A5A5A);

        // Grant statistics: 3 CPU accesses, 2 IOP windows.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_access(17'h21, 32'h0, 4'h0, 1'b0, 32'h0E000000, "st_cpu1");
        iop_window(17'h3F, 32'h0, 4'h0, "st_iop1");
        cpu_access(17'h21, 32'h0, 4'h0, 1'b0, 32'h0E000000, "st_cpu2");
        iop_window(17'h3F, 32'h0, 4'h0, "st_iop2");
        cpu_access(17'h21, 32'h0, 4'h0, 1'b0, 32'h0E000000, "st_cpu3");
`ifdef MEM_ARBITER_STATS_EN
        exp_cpu_cnt = 32'd3;
        exp_iop_cnt = 32'd2;
`else
        exp_cpu_cnt = 32'd0;
        exp_iop_cnt = 32'd0;
`endif
        check("stats_cpu", 32'(cpu_grant_count), exp_cpu_cnt);
        check("stats_iop", 32'(iop_grant_count), exp_iop_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
